// File: rtl/bcd_serial_digit_rx_pkg.sv
// Shared types and constants for the serial BCD digit receiver.
// State encodings and error codes are fixed so downstream logic can decode them directly.
package bcd_serial_digit_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10
  } state_t;

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_serial_digit_rx_check.sv
// Combinational frame checker: parity against the selected sense and decimal range of the digit.
module bcd_digit_check
  import bcd_serial_digit_rx_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       parity_bit,
  input  logic       parity_odd,
  output logic       parity_ok,
  output logic       range_ok
);

  assign parity_ok = ((^digit) ^ parity_bit) == parity_odd;
  assign range_ok  = digit <= BCD_MAX;

endmodule

// File: rtl/bcd_serial_digit_rx.sv
// Serial receiver for one framed BCD digit (start, 4 data, parity) feeding a
// one-entry holding register with a valid/ready handshake.
module bcd_serial_digit_rx
  import bcd_serial_digit_rx_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_en,
  input  logic       in_bit,
  input  logic       in_ready,
  output logic       out_A,
  output logic       out_B,
  output logic       out_C,
  output logic       out_D,
  output logic       out_valid,
  output logic       out_err,
  output logic [1:0] out_err_code,
  output logic       out_busy
);

  state_t     state, state_nxt;
  logic [1:0] bit_cnt;
  logic [3:0] shift_reg;
  logic [3:0] shift_nxt;
  logic [3:0] held;
  logic       frame_done;
  logic       parity_ok;
  logic       range_ok;
  logic       overrun;
  logic       accept;

  bcd_digit_check u_check (
    .digit      (shift_reg),
    .parity_bit (in_bit),
    .parity_odd (PARITY_ODD),
    .parity_ok  (parity_ok),
    .range_ok   (range_ok)
  );

  assign shift_nxt = MSB_FIRST ? {shift_reg[2:0], in_bit} : {in_bit, shift_reg[3:1]};

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (in_en && !in_bit) state_nxt = DATA;
      DATA:   if (in_en && bit_cnt == 2'd3) state_nxt = PARITY;
      PARITY: if (in_en) begin
                state_nxt  = IDLE;
                frame_done = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      bit_cnt   <= 2'd0;
      shift_reg <= 4'd0;
    end else if (in_en) begin
      if (state == IDLE && !in_bit) begin
        bit_cnt   <= 2'd0;
        shift_reg <= 4'd0;
      end else if (state == DATA) begin
        bit_cnt   <= bit_cnt + 2'd1;
        shift_reg <= shift_nxt;
      end
    end
  end

  // A consume on the parity edge frees the slot, so it does not count as overrun.
  assign overrun = out_valid && !in_ready;
  assign accept  = frame_done && parity_ok && range_ok && !overrun;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      held         <= 4'd0;
      out_valid    <= 1'b0;
      out_err      <= 1'b0;
      out_err_code <= 2'b00;
    end else begin
      if (accept) begin
        held      <= shift_reg;
        out_valid <= 1'b1;
      end else if (out_valid && in_ready) begin
        out_valid <= 1'b0;
      end
      out_err <= frame_done && !accept;
      if (frame_done && !accept) begin
        if (!parity_ok)     out_err_code <= ERR_PARITY;
        else if (!range_ok) out_err_code <= ERR_RANGE;
        else                out_err_code <= ERR_OVERRUN;
      end
    end
  end

  assign {out_A, out_B, out_C, out_D} = held;
  assign out_busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_serial_digit_rx.sv
// Directed, table-driven bench for bcd_serial_digit_rx (even/MSB-first instance)
// plus a second odd-parity/LSB-first instance for the alternate configuration.
module tb_bcd_serial_digit_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_en = 1'b0;
  logic       in_bit = 1'b1;
  logic       in_ready = 1'b0;
  logic       a1, b1, c1, d1, valid1, err1, busy1;
  logic [1:0] code1;
  logic       a2, b2, c2, d2, valid2, err2, busy2;
  logic [1:0] code2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] bits;
    logic       par;
    logic       pre_consume;
    logic       ready_par;
    logic       gap;
    logic [3:0] exp_abcd;
    logic       exp_valid;
    logic       exp_err;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  bcd_serial_digit_rx #(.PARITY_ODD(1'b0), .MSB_FIRST(1'b1)) dut (
    .in_clk(clk), .in_rst(rst), .in_en(in_en), .in_bit(in_bit), .in_ready(in_ready),
    .out_A(a1), .out_B(b1), .out_C(c1), .out_D(d1), .out_valid(valid1),
    .out_err(err1), .out_err_code(code1), .out_busy(busy1)
  );

  bcd_serial_digit_rx #(.PARITY_ODD(1'b1), .MSB_FIRST(1'b0)) dut_alt (
    .in_clk(clk), .in_rst(rst), .in_en(in_en), .in_bit(in_bit), .in_ready(in_ready),
    .out_A(a2), .out_B(b2), .out_C(c2), .out_D(d2), .out_valid(valid2),
    .out_err(err2), .out_err_code(code2), .out_busy(busy2)
  );

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One strobed bit; a gap adds an in_en=0 cycle with a misleading line level.
  task automatic driveBit(input logic b, input logic gap, input logic rdy);
    @(negedge clk);
    in_en = 1'b1; in_bit = b; in_ready = rdy;
    if (gap) begin
      @(negedge clk);
      in_en = 1'b0; in_bit = ~b; in_ready = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] bits, input logic par,
                               input logic ready_par, input logic gap);
    driveBit(1'b0, gap, 1'b0);
    for (int i = 3; i >= 0; i--) driveBit(bits[i], gap, 1'b0);
    driveBit(par, 1'b0, ready_par);
    @(negedge clk);
    in_en = 1'b0; in_bit = 1'b1; in_ready = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 2'b00};
    vecs[1] = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 2'b00};
    vecs[2] = '{4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 2'b01};
    vecs[3] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 2'b10};
    vecs[4] = '{4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 2'b10};
    vecs[5] = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1, 2'b11};
    vecs[6] = '{4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, 2'b11};
    vecs[7] = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b1, 2'b01};
    vecs[8] = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b0, 2'b01};
    vecs[9] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b01};

    #2;
    checkOutput("reset_abcd", {a1, b1, c1, d1}, 4'b0000);
    checkOutput("reset_valid", {3'b0, valid1}, 4'd0);
    checkOutput("reset_busy", {3'b0, busy1}, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load state worth clearing: a held digit and a non-zero error code.
    applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_odd_parity_err", {3'b0, err1}, 4'd1);
    consume();
    applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_abcd", {a1, b1, c1, d1}, 4'b0111);
    checkOutput("pre_valid", {3'b0, valid1}, 4'd1);

    driveBit(1'b0, 1'b0, 1'b0);
    driveBit(1'b1, 1'b0, 1'b0);
    driveBit(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_en = 1'b0; in_bit = 1'b1;
    checkOutput("mid_busy", {3'b0, busy1}, 4'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_abcd", {a1, b1, c1, d1}, 4'b0000);
    checkOutput("midrst_valid", {3'b0, valid1}, 4'd0);
    checkOutput("midrst_err", {1'b0, err1, code1}, 4'd0);
    checkOutput("midrst_busy", {3'b0, busy1}, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_consume) consume();
      applyStimulus(vecs[i].bits, vecs[i].par, vecs[i].ready_par, vecs[i].gap);
      checkOutput($sformatf("v%0d_abcd", i), {a1, b1, c1, d1}, vecs[i].exp_abcd);
      checkOutput($sformatf("v%0d_valid", i), {3'b0, valid1}, {3'b0, vecs[i].exp_valid});
      checkOutput($sformatf("v%0d_err", i), {3'b0, err1}, {3'b0, vecs[i].exp_err});
      if (vecs[i].exp_err)
        checkOutput($sformatf("v%0d_code", i), {2'b0, code1}, {2'b0, vecs[i].exp_code});
      @(negedge clk);
      checkOutput($sformatf("v%0d_err_gone", i), {3'b0, err1}, 4'd0);
      checkOutput($sformatf("v%0d_code_hold", i), {2'b0, code1}, {2'b0, vecs[i].exp_code});
      checkOutput($sformatf("v%0d_idle", i), {3'b0, busy1}, 4'd0);
      if (i == 1) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checkOutput("hold_valid", {3'b0, valid1}, 4'd1);
        end
        checkOutput("hold_abcd", {a1, b1, c1, d1}, 4'b1001);
        consume();
        checkOutput("consumed_valid", {3'b0, valid1}, 4'd0);
        checkOutput("consumed_abcd", {a1, b1, c1, d1}, 4'b1001);
      end
    end

    // Odd parity, LSB-first instance: serial 1,0,0,0 lands in D.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("alt_abcd", {a2, b2, c2, d2}, 4'b0001);
    checkOutput("alt_valid", {3'b0, valid2}, 4'd1);
    checkOutput("alt_err", {3'b0, err2}, 4'd0);
    consume();
    applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0);
    checkOutput("alt_abcd2", {a2, b2, c2, d2}, 4'b0110);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    checkOutput("alt_parity_err", {1'b0, err2, code2}, {1'b0, 1'b1, 2'b01});
    checkOutput("alt_abcd_kept", {a2, b2, c2, d2}, 4'b0110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_digit_rx.md
Name: bcd_serial_digit_rx

Overview:
- Upstream feeder for the team's 4-bit BCD code converter (inputs in_A..in_D).
- Receives one framed BCD digit at a time over a single-bit serial line and checks parity and decimal range.
- Holds each accepted digit in a one-entry output register with a valid/ready handshake, so the converter sees stable A,B,C,D until the digit is consumed.

Parameters:
- PARITY_ODD, 0, 0 = even parity (data bits plus parity bit have an even count of ones); 1 = odd parity.
- MSB_FIRST, 1, 1 = first data bit is A (MSB); 0 = first data bit is D (LSB).

Ports:
- in_clk  input  1  system clock; all state changes on the rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_en  input  1  bit strobe; in_bit is sampled only on edges where in_en=1.
- in_bit  input  1  serial line; idle level 1.
- in_ready  input  1  downstream accepts the held digit when out_valid=1 and in_ready=1.
- out_A  output  1  held digit bit 3 (MSB).
- out_B  output  1  held digit bit 2.
- out_C  output  1  held digit bit 1.
- out_D  output  1  held digit bit 0 (LSB).
- out_valid  output  1  held digit is valid.
- out_err  output  1  one-cycle pulse: frame rejected or dropped.
- out_err_code  output  2  qualified by out_err: 01 parity, 10 range (>9), 11 overrun.
- out_busy  output  1  1 while a frame is in progress (state other than IDLE).

Behaviour:
- Reset (asynchronous, any cycle, including mid-frame):
  - Outputs: out_A..out_D=0, out_valid=0, out_err=0, out_err_code=00, out_busy=0.
  - FSM to IDLE, bit counter 0, shift register 0.
- Frame format: start bit (0), 4 data bits, 1 parity bit. No stop bit is needed; the line returns to 1 between frames.
- FSM states and transitions:
  - IDLE: on in_en=1 with in_bit=0, go to DATA and clear the bit counter. in_bit=1 stays in IDLE.
  - DATA: on each in_en=1, shift in in_bit and increment the counter. After the 4th data bit, go to PARITY.
  - PARITY: on in_en=1, sample the parity bit, evaluate the frame, then go to IDLE.
- Evaluation priority, decided at the parity-bit edge:
  - Parity error first, then range error, then overrun.
  - Parity error: the ones-count of data+parity does not match PARITY_ODD.
  - Range error: the data value is 1010..1111.
  - Overrun: out_valid=1 and in_ready=0 on that edge.
- Accepted frame: out_A..out_D load on the same edge that samples the parity bit. out_valid=1 from the next cycle. Latency is 0 clocks after the final in_en edge.
- Rejected frame:
  - Output register and out_valid are unchanged.
  - out_err=1 for exactly one cycle with the matching code.
  - The rejected digit is discarded.
- Handshake:
  - When out_valid=1 and in_ready=1 on an edge, the digit is consumed and out_valid goes to 0.
  - out_A..out_D keep their last value; they are not cleared on consume.
  - Consume and a new acceptance on the same edge: the new digit loads, out_valid stays 1, no overrun.
- in_ready while out_valid=0 is ignored.
- in_en=0 edges freeze the FSM, counter and shift register. The handshake and out_err pulse timing still advance every clock.
- out_err is never asserted on consecutive cycles from one frame. out_err_code holds its last value when out_err=0.
- Shift order:
  - MSB_FIRST=1: first data bit goes to A.
  - MSB_FIRST=0: first data bit goes to D.

Decomposition:
- Shared package holds:
  - FSM state encodings IDLE=2'b00, DATA=2'b01, PARITY=2'b10.
  - Error codes ERR_PARITY=2'b01, ERR_RANGE=2'b10, ERR_OVERRUN=2'b11.
  - Constant BCD_MAX=4'd9.
- One natural sub-module: bcd_digit_check. It is combinational: 4-bit digit, parity bit and PARITY_ODD in; parity_ok and range_ok out.
- FSM, shift register and holding register stay in the top.

Test Plan:
- Reset mid-frame: assert in_rst after start bit and 2 data bits. Required: all outputs 0 immediately, out_busy=0. Then frame 0,0110,p=0 gives out_ABCD=0110, out_valid=1.
- Even parity, MSB_FIRST=1, in_ready=0: frame 0,1001,p=0. Required: out_ABCD=1001, out_valid=1 held for 10 cycles, no out_err. Then in_ready=1 for one cycle: out_valid=0, out_ABCD still 1001.
- Parity error: frame 0,0110,p=1. Required: out_err=1 for one cycle, out_err_code=01, out_valid and out_ABCD unchanged.
- Range error: frame 0,1010,p=0. Required: out_err=1, out_err_code=10, digit not loaded.
- Overrun then simultaneous consume:
  - Hold 0011 with in_ready=0, then send 0,0101,p=0. Required: out_err_code=11, out_ABCD stays 0011.
  - Repeat the 0101 frame with in_ready=1 on the parity edge. Required: out_ABCD=0101, out_valid stays 1, no out_err.
- MSB_FIRST=0 and PARITY_ODD=1: serial bits 0, then 1,0,0,0, then p=0. Required: out_ABCD=0001, out_valid=1.
